// File: rtl/tensor_pe_sequencer.sv
// Steps one tensor PE through multi-beat tile operations for several warps.
// Round-robin grant, NUM_STEPS operand beats, optional register writeback.
module tensor_pe_sequencer #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_TILES = 2,
  parameter int NUM_STEPS = 4,
  parameter int RDW       = 5,
  localparam int WIDW     = $clog2(NUM_WARPS),
  localparam int TILEW    = $clog2(NUM_TILES),
  localparam int STEPW    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           req_valid,
  output logic [NUM_WARPS-1:0]           req_ready,
  input  logic [NUM_WARPS*TILEW-1:0]     req_tile,
  input  logic [NUM_WARPS-1:0]           req_wb,
  input  logic [NUM_WARPS*RDW-1:0]       req_rd,
  output logic                           pe_valid,
  input  logic                           pe_ready,
  output logic [STEPW-1:0]               pe_step,
  output logic [WIDW-1:0]                pe_wid,
  output logic [TILEW-1:0]               pe_tile,
  output logic                           pe_first,
  output logic                           pe_last,
  output logic [NUM_WARPS*NUM_TILES-1:0] tile_shift_en,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [WIDW-1:0]                wb_wid,
  output logic [RDW-1:0]                 wb_rd,
  output logic                           busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_t;

  state_t           state;
  logic [STEPW-1:0] step;
  logic [WIDW-1:0]  rr_ptr;
  logic [WIDW-1:0]  lat_wid;
  logic [TILEW-1:0] lat_tile;
  logic             lat_wb;
  logic [RDW-1:0]   lat_rd;

  logic             grant_valid;
  logic [WIDW-1:0]  grant_id;
  logic [WIDW-1:0]  probe;
  logic             beat_fire;
  logic             step_last;

  // Scan from the highest offset down so the warp nearest rr_ptr is written last and wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    probe       = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      probe = rr_ptr + WIDW'(i);
      if (req_valid[probe]) begin
        grant_valid = 1'b1;
        grant_id    = probe;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && reset && grant_valid) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign step_last = (step == STEPW'(NUM_STEPS - 1));
  assign beat_fire = (state == S_ISSUE) && pe_ready;

  always_comb begin
    tile_shift_en = '0;
    if (beat_fire) begin
      tile_shift_en[{lat_wid, lat_tile}] = 1'b1;
    end
  end

  assign pe_valid = (state == S_ISSUE);
  assign pe_step  = step;
  assign pe_wid   = lat_wid;
  assign pe_tile  = lat_tile;
  assign pe_first = pe_valid && (step == '0);
  assign pe_last  = pe_valid && step_last;
  assign wb_valid = (state == S_WB);
  assign wb_wid   = lat_wid;
  assign wb_rd    = lat_rd;
  assign busy     = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      step     <= '0;
      rr_ptr   <= '0;
      lat_wid  <= '0;
      lat_tile <= '0;
      lat_wb   <= 1'b0;
      lat_rd   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            lat_wid  <= grant_id;
            lat_tile <= req_tile[grant_id*TILEW +: TILEW];
            lat_wb   <= req_wb[grant_id];
            lat_rd   <= req_rd[grant_id*RDW +: RDW];
            step     <= '0;
            rr_ptr   <= grant_id + WIDW'(1);
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pe_ready) begin
            if (step_last) begin
              step  <= '0;
              state <= lat_wb ? S_WB : S_IDLE;
            end else begin
              step <= step + STEPW'(1);
            end
          end
        end
        S_WB: begin
          if (wb_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_pe_sequencer.sv
// Directed bench for tensor_pe_sequencer: a 4-beat build and a 1-beat build
// driven from one linear stimulus sequence with hand-computed expectations.
module tb_tensor_pe_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, req_tile, req_wb;
  logic [19:0] req_rd;
  logic        pe_valid, pe_ready, pe_first, pe_last;
  logic [1:0]  pe_step, pe_wid;
  logic        pe_tile;
  logic [7:0]  tile_shift_en;
  logic        wb_valid, wb_ready;
  logic [1:0]  wb_wid;
  logic [4:0]  wb_rd;
  logic        busy;

  logic [3:0]  o_req_valid, o_req_ready, o_req_tile, o_req_wb;
  logic [19:0] o_req_rd;
  logic        o_pe_valid, o_pe_ready, o_pe_first, o_pe_last;
  logic        o_pe_step;
  logic [1:0]  o_pe_wid;
  logic        o_pe_tile;
  logic [7:0]  o_tile_shift_en;
  logic        o_wb_valid, o_wb_ready;
  logic [1:0]  o_wb_wid;
  logic [4:0]  o_wb_rd;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tensor_pe_sequencer #(.NUM_WARPS(4), .NUM_TILES(2), .NUM_STEPS(4), .RDW(5)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tile(req_tile),
    .req_wb(req_wb), .req_rd(req_rd),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_step(pe_step),
    .pe_wid(pe_wid), .pe_tile(pe_tile), .pe_first(pe_first), .pe_last(pe_last),
    .tile_shift_en(tile_shift_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_rd(wb_rd),
    .busy(busy)
  );

  tensor_pe_sequencer #(.NUM_WARPS(4), .NUM_TILES(2), .NUM_STEPS(1), .RDW(5)) u_one (
    .clk(clk), .reset(reset),
    .req_valid(o_req_valid), .req_ready(o_req_ready), .req_tile(o_req_tile),
    .req_wb(o_req_wb), .req_rd(o_req_rd),
    .pe_valid(o_pe_valid), .pe_ready(o_pe_ready), .pe_step(o_pe_step),
    .pe_wid(o_pe_wid), .pe_tile(o_pe_tile), .pe_first(o_pe_first), .pe_last(o_pe_last),
    .tile_shift_en(o_tile_shift_en),
    .wb_valid(o_wb_valid), .wb_ready(o_wb_ready), .wb_wid(o_wb_wid), .wb_rd(o_wb_rd),
    .busy(o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled in the low phase, after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int shifts;
    int exp_step;
    logic pr;
    logic [9:0] bp_pattern;
    int rr_order [5];

    rr_order   = '{0, 1, 2, 3, 0};
    bp_pattern = 10'b1001001001;

    reset = 1'b0;
    req_valid = 4'hF; req_tile = '0; req_wb = '0; req_rd = '0;
    pe_ready = 1'b1; wb_ready = 1'b0;
    o_req_valid = '0; o_req_tile = '0; o_req_wb = '0; o_req_rd = '0;
    o_pe_ready = 1'b1; o_wb_ready = 1'b0;

    // Reset state, with requests held to prove req_ready stays low in reset.
    tick(); tick();
    #1;
    check("rst_req_ready", req_ready, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_pe_valid", pe_valid, 0);
    check("rst_pe_first_last", {pe_first, pe_last}, 0);
    check("rst_shift", tile_shift_en, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fields", {pe_step, pe_wid, pe_tile, wb_wid, wb_rd}, 0);
    check("rst_one_busy", o_busy, 0);

    // Single request: warp 2, tile 1, wb=1, rd=7.
    reset = 1'b1;
    req_valid = 4'b0100; req_tile = 4'b0100; req_wb = 4'b0100; req_rd = 20'd7 << 10;
    #1;
    check("single_grant", req_ready, 4'b0100);
    check("single_idle_busy", busy, 0);
    tick();
    req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      #1;
      check("single_pe_valid", pe_valid, 1);
      check("single_pe_step", pe_step, s);
      check("single_first", pe_first, (s == 0));
      check("single_last", pe_last, (s == 3));
      check("single_wid_tile", {pe_wid, pe_tile}, {2'd2, 1'b1});
      check("single_shift", tile_shift_en, 8'h20);
      check("single_req_ready", req_ready, 4'h0);
      tick();
    end

    // Writeback stall with another warp waiting.
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("wbstall_valid", wb_valid, 1);
      check("wbstall_fields", {wb_wid, wb_rd}, {2'd2, 5'd7});
      check("wbstall_req_ready", req_ready, 4'h0);
      check("wbstall_shift", tile_shift_en, 0);
      check("wbstall_busy", busy, 1);
      tick();
    end
    req_valid = '0;
    wb_ready = 1'b1;
    #1;
    check("wb_handshake_valid", wb_valid, 1);
    tick();
    wb_ready = 1'b0;
    #1;
    check("post_wb_busy", busy, 0);
    check("post_wb_valid", wb_valid, 0);

    // Reset mid-ISSUE at step 2: warp 1, tile 0, wb=1, rd=3 (rr_ptr is 3 here).
    req_valid = 4'b0010; req_tile = '0; req_wb = 4'b0010; req_rd = 20'd3 << 5;
    #1;
    check("midrst_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick(); tick();
    #1;
    check("midrst_step2", pe_step, 2);
    check("midrst_shift_pre", tile_shift_en, 8'h04);
    reset = 1'b0;
    req_valid = 4'hF; req_wb = '0;
    #1;
    check("midrst_req_ready_in_reset", req_ready, 4'h0);
    tick();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pe_valid", pe_valid, 0);
    check("midrst_shift", tile_shift_en, 0);
    check("midrst_wb_valid", wb_valid, 0);
    check("midrst_fields", {pe_step, pe_wid, pe_tile, wb_wid, wb_rd}, 0);
    reset = 1'b1;

    // Round-robin: all warps requesting continuously with wb=0.
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", req_ready, 4'b0001 << rr_order[k]);
      tick();
      for (int s = 0; s < 4; s++) begin
        #1;
        check("rr_pe_wid", {pe_valid, pe_wid}, {1'b1, 2'(rr_order[k])});
        check("rr_wb_valid", wb_valid, 0);
        tick();
      end
    end

    // PE backpressure: warp 0, tile 1; rr_ptr is 1 so the search wraps to 0.
    req_valid = 4'b0001; req_tile = 4'b0001;
    #1;
    check("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    shifts = 0;
    exp_step = 0;
    for (int c = 0; c < 10; c++) begin
      pr = bp_pattern[c];
      pe_ready = pr;
      #1;
      check("bp_pe_valid", pe_valid, 1);
      check("bp_pe_step", pe_step, exp_step);
      check("bp_first_last", {pe_first, pe_last}, {exp_step == 0, exp_step == 3});
      check("bp_shift", tile_shift_en, pr ? 8'h02 : 8'h00);
      if (tile_shift_en != 0) shifts++;
      if (pr) exp_step++;
      tick();
    end
    pe_ready = 1'b1;
    #1;
    check("bp_shift_count", shifts, 4);
    check("bp_done_busy", busy, 0);
    check("bp_no_wb", wb_valid, 0);

    // NUM_STEPS=1 build: warp 1, tile 0, wb=0.
    o_req_valid = 4'b0010;
    #1;
    check("one_grant", o_req_ready, 4'b0010);
    tick();
    o_req_valid = '0;
    #1;
    check("one_beat", {o_pe_valid, o_pe_first, o_pe_last, o_pe_step}, 4'b1110);
    check("one_shift", o_tile_shift_en, 8'h04);
    tick();
    #1;
    check("one_idle_busy", o_busy, 0);
    check("one_no_wb", o_wb_valid, 0);
    check("one_shift_off", o_tile_shift_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
